// File: rtl/world_pkg.sv
// Shared types and constants for the world scheduler: FSM states, the layout of
// a world memory entry and the "no cube" marker.
package world_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_DISPATCH = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_COMMIT   = 3'd4
   } state_e;

   // World entry is {valid, x, y, z}; each coordinate field is half a corner wide.
   localparam int unsigned FLD_Z     = 0;
   localparam int unsigned FLD_Y     = 1;
   localparam int unsigned FLD_X     = 2;
   localparam int unsigned FLD_VALID = 3;

   localparam logic [31:0] NO_CUBE = 32'hFFFF_FFFF;

   function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned half_w);
      return idx * half_w;
   endfunction

endpackage

// File: rtl/world_scheduler_if.sv
// Channel-side bus of the world scheduler: dispatch fields out to the cube
// drawers, status and pick results back from them.
interface world_scheduler_if #(
   parameter int COORD_WIDTH     = 32,
   parameter int DEPTH_BIT_WIDTH = 16,
   parameter int WORLD_BITS      = 7,
   parameter int NORMAL_WIDTH    = 2,
   parameter int NUM_CH          = 2
);
   logic [NUM_CH-1:0]                       ch_start;
   logic [NUM_CH-1:0]                       ch_busy;
   logic [NUM_CH-1:0]                       ch_done;
   logic [NUM_CH-1:0]                       ch_hit;
   logic [NUM_CH-1:0][DEPTH_BIT_WIDTH-1:0]  ch_hit_depth;
   logic [NUM_CH-1:0][3*NORMAL_WIDTH-1:0]   ch_hit_normal;
   logic [COORD_WIDTH-1:0]                  x_corner;
   logic [COORD_WIDTH-1:0]                  y_corner;
   logic [COORD_WIDTH-1:0]                  z_corner;
   logic [WORLD_BITS-1:0]                   cube_id;
   logic                                    highlight;

   modport master (
      output ch_start, x_corner, y_corner, z_corner, cube_id, highlight,
      input  ch_busy, ch_done, ch_hit, ch_hit_depth, ch_hit_normal
   );

   modport slave (
      input  ch_start, x_corner, y_corner, z_corner, cube_id, highlight,
      output ch_busy, ch_done, ch_hit, ch_hit_depth, ch_hit_normal
   );
endinterface

// File: rtl/center_pick_reducer.sv
// Registered minimum-depth reducer over the per-channel centre-pixel hits.
// Strict less-than keeps the earliest hit across cycles and the lowest channel within one.
module center_pick_reducer
   import world_pkg::*;
#(
   parameter int NUM_CH          = 2,
   parameter int DEPTH_BIT_WIDTH = 16,
   parameter int WORLD_BITS      = 7,
   parameter int NORMAL_WIDTH    = 2
) (
   input  logic                                  clk_in,
   input  logic                                  rst_n_in,
   input  logic                                  clear,
   input  logic                                  enable,
   input  logic [NUM_CH-1:0]                     hit,
   input  logic [NUM_CH-1:0][DEPTH_BIT_WIDTH-1:0] depth,
   input  logic [NUM_CH-1:0][WORLD_BITS-1:0]     id,
   input  logic [NUM_CH-1:0][3*NORMAL_WIDTH-1:0] normal,
   output logic [DEPTH_BIT_WIDTH-1:0]            best_depth,
   output logic [WORLD_BITS-1:0]                 best_id,
   output logic [3*NORMAL_WIDTH-1:0]             best_normal
);

   logic [DEPTH_BIT_WIDTH-1:0] best_depth_d, best_depth_q;
   logic [WORLD_BITS-1:0]      best_id_d, best_id_q;
   logic [3*NORMAL_WIDTH-1:0]  best_normal_d, best_normal_q;
   logic                       take_s;

   // Next best candidate: clear at frame start, otherwise fold in this cycle's hits.
   always_comb begin
      best_depth_d  = best_depth_q;
      best_id_d     = best_id_q;
      best_normal_d = best_normal_q;
      take_s        = 1'b0;
      if (clear) begin
         best_depth_d  = '1;
         best_id_d     = WORLD_BITS'(NO_CUBE);
         best_normal_d = '0;
      end else if (enable) begin
         for (int i = 0; i < NUM_CH; i++) begin
            take_s        = hit[i] && (depth[i] < best_depth_d);
            best_depth_d  = take_s ? depth[i]  : best_depth_d;
            best_id_d     = take_s ? id[i]     : best_id_d;
            best_normal_d = take_s ? normal[i] : best_normal_d;
         end
      end else begin
         best_depth_d  = best_depth_q;
      end
   end

   // Best-hit registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         best_depth_q  <= '1;
         best_id_q     <= WORLD_BITS'(NO_CUBE);
         best_normal_q <= '0;
      end else begin
         best_depth_q  <= best_depth_d;
         best_id_q     <= best_id_d;
         best_normal_q <= best_normal_d;
      end
   end

   assign best_depth  = best_depth_q;
   assign best_id     = best_id_q;
   assign best_normal = best_normal_q;

endmodule

// File: rtl/world_scheduler.sv
// Walks the world memory once per frame, hands each valid cube to the lowest free
// cube drawer channel and commits the nearest centre-pixel hit as the looked-at cube.
module world_scheduler
   import world_pkg::*;
#(
   parameter int COORD_WIDTH     = 32,
   parameter int DEPTH_BIT_WIDTH = 16,
   parameter int WORLD_SIZE      = 100,
   parameter int WORLD_BITS      = 7,
   parameter int NORMAL_WIDTH    = 2,
   parameter int NUM_CH          = 2,
   parameter int READ_LATENCY    = 2
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          start,
   input  logic [3*COORD_WIDTH/2:0]      world_read,
   output logic [WORLD_BITS-1:0]         world_read_addr,
   world_scheduler_if.master             ch,
   output logic                          busy,
   output logic                          done,
   output logic [WORLD_BITS-1:0]         looked_at_cube,
   output logic [3*NORMAL_WIDTH-1:0]     looked_at_normal,
   output logic [WORLD_BITS:0]           cubes_drawn
);

   localparam int unsigned H       = COORD_WIDTH / 2;
   localparam int unsigned X_LSB   = field_lsb(FLD_X, H);
   localparam int unsigned Y_LSB   = field_lsb(FLD_Y, H);
   localparam int unsigned Z_LSB   = field_lsb(FLD_Z, H);
   localparam int unsigned V_BIT   = field_lsb(FLD_VALID, H);

   state_e                           state_d, state_q;
   logic [WORLD_BITS-1:0]            addr_d, addr_q;
   logic [2:0]                       lat_d, lat_q;
   logic [H-1:0]                     ent_x_d, ent_x_q, ent_y_d, ent_y_q, ent_z_d, ent_z_q;
   logic [NUM_CH-1:0]                ch_start_d, ch_start_q;
   logic [NUM_CH-1:0]                pend_d, pend_q;
   logic [NUM_CH-1:0][WORLD_BITS-1:0] ch_id_d, ch_id_q;
   logic [COORD_WIDTH-1:0]           x_d, x_q, y_d, y_q, z_d, z_q;
   logic [WORLD_BITS-1:0]            cube_id_d, cube_id_q;
   logic                             hl_d, hl_q;
   logic                             busy_d, busy_q, done_d, done_q;
   logic [WORLD_BITS-1:0]            look_cube_d, look_cube_q;
   logic [3*NORMAL_WIDTH-1:0]        look_norm_d, look_norm_q;
   logic [WORLD_BITS:0]              cubes_d, cubes_q;

   logic [NUM_CH-1:0]                free_s, grant_s;
   logic                             found_s, last_s, clear_s, pick_en_s;
   logic [DEPTH_BIT_WIDTH-1:0]       best_depth_s;
   logic [WORLD_BITS-1:0]            best_id_s;
   logic [3*NORMAL_WIDTH-1:0]        best_norm_s;

   assign clear_s   = (state_q == ST_IDLE) && start;
   assign pick_en_s = (state_q != ST_IDLE);
   assign last_s    = (addr_q == WORLD_BITS'(WORLD_SIZE - 1));
   assign free_s    = ~ch.ch_busy & ~pend_q;

   center_pick_reducer #(
      .NUM_CH(NUM_CH), .DEPTH_BIT_WIDTH(DEPTH_BIT_WIDTH),
      .WORLD_BITS(WORLD_BITS), .NORMAL_WIDTH(NORMAL_WIDTH)
   ) u_pick (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .clear(clear_s), .enable(pick_en_s),
      .hit(ch.ch_hit), .depth(ch.ch_hit_depth), .id(ch_id_q), .normal(ch.ch_hit_normal),
      .best_depth(best_depth_s), .best_id(best_id_s), .best_normal(best_norm_s)
   );

   // Lowest-index free channel as a one-hot grant.
   always_comb begin
      grant_s = '0;
      found_s = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         grant_s[i] = free_s[i] && !found_s;
         found_s    = found_s || free_s[i];
      end
   end

   // Frame FSM next state and datapath.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      lat_d       = lat_q;
      ent_x_d     = ent_x_q;
      ent_y_d     = ent_y_q;
      ent_z_d     = ent_z_q;
      ch_start_d  = '0;
      // A start in flight keeps its channel pending even if done arrives with it.
      pend_d      = (pend_q & ~ch.ch_done) | ch_start_q;
      ch_id_d     = ch_id_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      cube_id_d   = cube_id_q;
      hl_d        = hl_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      look_cube_d = look_cube_q;
      look_norm_d = look_norm_q;
      cubes_d     = cubes_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = '0;
               lat_d   = 3'd0;
               cubes_d = '0;
               busy_d  = 1'b1;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (lat_q == 3'(READ_LATENCY)) begin
               lat_d = 3'd0;
               if (world_read[V_BIT]) begin
                  ent_x_d = world_read[X_LSB +: H];
                  ent_y_d = world_read[Y_LSB +: H];
                  ent_z_d = world_read[Z_LSB +: H];
                  state_d = ST_DISPATCH;
               end else if (last_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  addr_d  = addr_q + WORLD_BITS'(1);
               end
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         ST_DISPATCH: begin
            if (found_s) begin
               ch_start_d = grant_s;
               pend_d     = pend_d | grant_s;
               for (int i = 0; i < NUM_CH; i++) begin
                  ch_id_d[i] = grant_s[i] ? addr_q : ch_id_q[i];
               end
               x_d       = {ent_x_q, {H{1'b0}}};
               y_d       = {ent_y_q, {H{1'b0}}};
               z_d       = {ent_z_q, {H{1'b0}}};
               cube_id_d = addr_q;
               hl_d      = (addr_q == look_cube_q);
               cubes_d   = cubes_q + (WORLD_BITS+1)'(1);
               if (last_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  addr_d  = addr_q + WORLD_BITS'(1);
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = ST_DISPATCH;
            end
         end
         ST_DRAIN: begin
            if ((pend_q == '0) && (ch.ch_busy == '0)) begin
               state_d = ST_COMMIT;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_COMMIT: begin
            look_cube_d = (best_depth_s == '1) ? WORLD_BITS'(NO_CUBE) : best_id_s;
            look_norm_d = best_norm_s;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         lat_q       <= 3'd0;
         ent_x_q     <= '0;
         ent_y_q     <= '0;
         ent_z_q     <= '0;
         ch_start_q  <= '0;
         pend_q      <= '0;
         ch_id_q     <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         cube_id_q   <= '0;
         hl_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         look_cube_q <= WORLD_BITS'(NO_CUBE);
         look_norm_q <= '0;
         cubes_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         lat_q       <= lat_d;
         ent_x_q     <= ent_x_d;
         ent_y_q     <= ent_y_d;
         ent_z_q     <= ent_z_d;
         ch_start_q  <= ch_start_d;
         pend_q      <= pend_d;
         ch_id_q     <= ch_id_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         cube_id_q   <= cube_id_d;
         hl_q        <= hl_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         look_cube_q <= look_cube_d;
         look_norm_q <= look_norm_d;
         cubes_q     <= cubes_d;
      end
   end

   assign world_read_addr  = addr_q;
   assign ch.ch_start      = ch_start_q;
   assign ch.x_corner      = x_q;
   assign ch.y_corner      = y_q;
   assign ch.z_corner      = z_q;
   assign ch.cube_id       = cube_id_q;
   assign ch.highlight     = hl_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign looked_at_cube   = look_cube_q;
   assign looked_at_normal = look_norm_q;
   assign cubes_drawn      = cubes_q;

endmodule

// File: tb/tb_world_scheduler.sv
// Randomized frame-level bench for world_scheduler: a world memory model, simple
// cube drawer models and a hit scoreboard that predicts the looked-at cube.
module tb_world_scheduler;

   localparam int CW = 32, H = 16, DW = 16, WS = 100, WB = 7, NW = 2, NC = 2, RL = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, start;
   logic [3*H:0]      world_read;
   logic [WB-1:0]     world_read_addr;
   logic              busy, done;
   logic [WB-1:0]     looked_at_cube;
   logic [3*NW-1:0]   looked_at_normal;
   logic [WB:0]       cubes_drawn;

   world_scheduler_if #(.COORD_WIDTH(CW), .DEPTH_BIT_WIDTH(DW), .WORLD_BITS(WB),
                        .NORMAL_WIDTH(NW), .NUM_CH(NC)) bus ();

   world_scheduler #(.COORD_WIDTH(CW), .DEPTH_BIT_WIDTH(DW), .WORLD_SIZE(WS), .WORLD_BITS(WB),
                     .NORMAL_WIDTH(NW), .NUM_CH(NC), .READ_LATENCY(RL)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .start(start), .world_read(world_read),
      .world_read_addr(world_read_addr), .ch(bus), .busy(busy), .done(done),
      .looked_at_cube(looked_at_cube), .looked_at_normal(looked_at_normal),
      .cubes_drawn(cubes_drawn));

   typedef struct {int cyc; int ch; int id; int depth; logic [3*NW-1:0] nrm;} hit_t;

   int checks = 0, errors = 0;
   bit mem_v[WS];
   logic [H-1:0] mem_x[WS], mem_y[WS], mem_z[WS];
   int depth_of[WS];
   logic [3*NW-1:0] norm_of[WS];
   int dur[NC], hit_at[NC];
   bit hold[NC], act[NC];
   int cnt[NC], jid[NC];
   logic [3*H:0] pipe[RL];
   logic [WB-1:0] addr_prev;
   logic [NC-1:0] free_prev;
   int cyc, last_id, disp_cnt;
   int ch_of[WS];
   logic [CW-1:0] x_of[WS];
   bit hl_of[WS];
   logic [WB-1:0] prev_looked;
   hit_t hits[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: monitor dispatches, model memory latency and the drawers.
   task automatic tick();
      logic [NC-1:0] exp_vec;
      int id;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         for (int c = 0; c < NC; c++) act[c] = 1'b0;
         bus.ch_busy = '0; bus.ch_done = '0; bus.ch_hit = '0;
         for (int i = 0; i < RL; i++) pipe[i] = '0;
         world_read = '0; addr_prev = '0; free_prev = '1;
         return;
      end
      if (bus.ch_start != '0) begin
         id = int'(bus.cube_id);
         exp_vec = '0;
         for (int c = NC - 1; c >= 0; c--) if (free_prev[c]) begin exp_vec = '0; exp_vec[c] = 1'b1; end
         check_eq("ch_select", bus.ch_start, exp_vec);
         check_eq("id_order", (id > last_id) && (id < WS) && mem_v[id], 1);
         if (id < WS) begin
            check_eq("x_corner", bus.x_corner, {mem_x[id], 16'h0000});
            check_eq("y_corner", bus.y_corner, {mem_y[id], 16'h0000});
            check_eq("z_corner", bus.z_corner, {mem_z[id], 16'h0000});
            check_eq("highlight", bus.highlight, bus.cube_id == prev_looked);
            for (int c = 0; c < NC; c++) if (bus.ch_start[c]) ch_of[id] = c;
            x_of[id] = bus.x_corner;
            hl_of[id] = bus.highlight;
         end
         last_id = id;
         disp_cnt++;
      end
      for (int i = RL - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = (int'(addr_prev) < WS) ?
                {mem_v[addr_prev], mem_x[addr_prev], mem_y[addr_prev], mem_z[addr_prev]} : '0;
      world_read = pipe[RL-1];
      addr_prev = world_read_addr;
      for (int c = 0; c < NC; c++) begin
         bus.ch_hit[c] = 1'b0;
         bus.ch_done[c] = 1'b0;
         if (act[c]) begin
            cnt[c]++;
            if (cnt[c] == hit_at[c] && depth_of[jid[c]] >= 0) begin
               bus.ch_hit[c] = 1'b1;
               bus.ch_hit_depth[c] = DW'(depth_of[jid[c]]);
               bus.ch_hit_normal[c] = norm_of[jid[c]];
               hits.push_back('{cyc, c, jid[c], depth_of[jid[c]], norm_of[jid[c]]});
            end
            if (cnt[c] >= dur[c] && !hold[c]) begin
               bus.ch_done[c] = 1'b1; bus.ch_busy[c] = 1'b0; act[c] = 1'b0;
            end
         end else if (bus.ch_start[c]) begin
            act[c] = 1'b1; cnt[c] = 0; jid[c] = int'(bus.cube_id); bus.ch_busy[c] = 1'b1;
         end
         free_prev[c] = !act[c] && !bus.ch_done[c];
      end
   endtask

   task automatic clear_world();
      for (int i = 0; i < WS; i++) begin
         mem_v[i] = 1'b0; mem_x[i] = '0; mem_y[i] = '0; mem_z[i] = '0;
         depth_of[i] = -1; norm_of[i] = '0;
      end
   endtask

   task automatic random_world(input int pct);
      for (int i = 0; i < WS; i++) begin
         mem_v[i] = (int'($urandom_range(0, 99)) < pct);
         mem_x[i] = H'($urandom); mem_y[i] = H'($urandom); mem_z[i] = H'($urandom);
         depth_of[i] = (int'($urandom_range(0, 9)) < 8) ? int'($urandom_range(0, 600)) * 100 + i : -1;
         norm_of[i] = (3*NW)'($urandom);
      end
      for (int c = 0; c < NC; c++) begin
         dur[c] = int'($urandom_range(2, 8));
         hit_at[c] = int'($urandom_range(1, dur[c] - 1));
      end
   endtask

   task automatic frame_begin();
      hits.delete();
      last_id = -1; disp_cnt = 0;
      for (int i = 0; i < WS; i++) begin ch_of[i] = -1; hl_of[i] = 1'b0; x_of[i] = '0; end
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_disp(input int n);
      int k = 0;
      while (disp_cnt < n && k < 500) begin tick(); k++; end
      check_eq("disp_timeout", disp_cnt >= n, 1);
   endtask

   task automatic frame_end(input bit poke, output int ncyc);
      int nv = 0, bi = -1, k = 0;
      logic [WB-1:0] exp_look;
      logic [3*NW-1:0] exp_norm;
      while (!done && k < 5000) begin
         if (poke && k == 20) start = 1'b1;
         tick();
         start = 1'b0;
         k++;
      end
      ncyc = k;
      check_eq("done_seen", done, 1);
      for (int i = 0; i < WS; i++) nv += mem_v[i] ? 1 : 0;
      foreach (hits[j]) begin
         if (bi < 0 || hits[j].depth < hits[bi].depth ||
             (hits[j].depth == hits[bi].depth && (hits[j].cyc < hits[bi].cyc ||
              (hits[j].cyc == hits[bi].cyc && hits[j].ch < hits[bi].ch)))) bi = j;
      end
      exp_look = (bi < 0) ? 7'h7F : WB'(hits[bi].id);
      exp_norm = (bi < 0) ? '0 : hits[bi].nrm;
      check_eq("looked_cube", looked_at_cube, exp_look);
      check_eq("looked_normal", looked_at_normal, exp_norm);
      check_eq("cubes_drawn", cubes_drawn, nv);
      check_eq("dispatch_count", disp_cnt, nv);
      check_eq("busy_clear", busy, 0);
      tick();
      check_eq("done_pulse", done, 0);
      prev_looked = exp_look;
   endtask

   initial begin
      int ncyc;
      rst_n = 1'b0; start = 1'b0; world_read = '0; cyc = 0;
      bus.ch_busy = '0; bus.ch_done = '0; bus.ch_hit = '0;
      bus.ch_hit_depth = '0; bus.ch_hit_normal = '0;
      for (int c = 0; c < NC; c++) begin hold[c] = 1'b0; act[c] = 1'b0; dur[c] = 2; hit_at[c] = 1; end
      for (int i = 0; i < RL; i++) pipe[i] = '0;
      addr_prev = '0; free_prev = '1; prev_looked = 7'h7F;
      clear_world();
      #12;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_looked", looked_at_cube, 7'h7F);
      check_eq("rst_outs", {done, bus.ch_start, world_read_addr, cubes_drawn, looked_at_normal}, 0);
      rst_n = 1'b1;
      tick(); tick();

      // All entries invalid: latency and empty result.
      frame_begin();
      frame_end(1'b0, ncyc);
      check_eq("s1_latency", (ncyc >= WS*(RL+1)+1) && (ncyc <= WS*(RL+1)+3), 1);

      // Entries 3 and 4: second cube goes to ch1 while ch0 still draws.
      clear_world();
      mem_v[3] = 1'b1; mem_x[3] = 16'd5; mem_y[3] = 16'd7; mem_z[3] = 16'd9; depth_of[3] = 100;
      mem_v[4] = 1'b1; mem_x[4] = 16'd6; depth_of[4] = 50;
      dur[0] = 20; hit_at[0] = 1; dur[1] = 3; hit_at[1] = 1;
      frame_begin();
      frame_end(1'b0, ncyc);
      check_eq("s2_ch_cube3", ch_of[3], 0);
      check_eq("s2_ch_cube4", ch_of[4], 1);
      check_eq("s2_x_corner", x_of[3], 32'h0005_0000);

      // Same-cycle equal-depth hits: lower channel (cube 3) wins.
      depth_of[3] = 40; depth_of[4] = 40;
      dur[0] = 7; hit_at[0] = 5; dur[1] = 3; hit_at[1] = 1;
      frame_begin();
      frame_end(1'b0, ncyc);
      check_eq("s3_tie", looked_at_cube, 3);
      mem_v[5] = 1'b1; depth_of[3] = 900; depth_of[4] = 800; depth_of[5] = 700;
      frame_begin();
      frame_end(1'b0, ncyc);
      check_eq("s3_hl_cube3", hl_of[3], 1);
      check_eq("s3_hl_cube4", hl_of[4], 0);

      // Both channels held: dispatch stalls until ch1 is released.
      hold[0] = 1'b1; hold[1] = 1'b1;
      frame_begin();
      wait_disp(2);
      repeat (10) tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("s4_stall_start", bus.ch_start, 0);
         check_eq("s4_stall_addr", world_read_addr, 5);
      end
      hold[1] = 1'b0;
      wait_disp(3);
      check_eq("s4_ch_cube5", ch_of[5], 1);
      hold[0] = 1'b0;
      frame_end(1'b0, ncyc);

      // Reset asserted while stalled in dispatch.
      hold[0] = 1'b1; hold[1] = 1'b1;
      frame_begin();
      wait_disp(2);
      repeat (8) tick();
      rst_n = 1'b0;
      #2;
      check_eq("s5_busy", busy, 0);
      check_eq("s5_looked", looked_at_cube, 7'h7F);
      check_eq("s5_outs", {done, bus.ch_start, bus.highlight, bus.cube_id, world_read_addr,
                           cubes_drawn, looked_at_normal}, 0);
      check_eq("s5_corner", bus.x_corner | bus.y_corner | bus.z_corner, 0);
      tick(); tick();
      hold[0] = 1'b0; hold[1] = 1'b0; prev_looked = 7'h7F;
      rst_n = 1'b1;
      tick();

      // Random frames, one with a stray start while busy.
      for (int f = 0; f < 5; f++) begin
         random_world(15);
         frame_begin();
         frame_end(f == 2, ncyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/world_scheduler.md
WORLD_SCHEDULER -- requirements
Module: world_scheduler

Interface
REQ-001 SHALL have parameter COORD_WIDTH, default 32, cube corner coordinate width; fixed-point with integer part in the upper COORD_WIDTH/2 bits.
REQ-002 SHALL have parameter DEPTH_BIT_WIDTH, default 16, hit depth width.
REQ-003 SHALL have parameter WORLD_SIZE, default 100, number of world memory entries.
REQ-004 SHALL have parameter WORLD_BITS, default 7, world address width.
REQ-005 SHALL have parameter NORMAL_WIDTH, default 2, width of each normal component.
REQ-006 SHALL have parameter NUM_CH, default 2, number of cube drawer channels.
REQ-007 SHALL have parameter READ_LATENCY, default 2, world memory read latency in cycles (1..4).
REQ-008 SHALL have one clock; reset is asynchronous and active-low: clk_in, in, 1, rising-edge clock; rst_n_in, in, 1, asynchronous active-low reset.
REQ-009 SHALL have ports: start, in, 1, frame start pulse; world_read, in, 3*COORD_WIDTH/2+1, {valid, x, y, z}; world_read_addr, out, WORLD_BITS, memory address.
REQ-010 SHALL have per-channel ports: ch_start, out, NUM_CH, one-cycle start; ch_busy, in, NUM_CH; ch_done, in, NUM_CH, one-cycle; ch_hit, in, NUM_CH, centre pixel written this cycle; ch_hit_depth, in, NUM_CH x DEPTH_BIT_WIDTH; ch_hit_normal, in, NUM_CH x 3 x NORMAL_WIDTH.
REQ-011 SHALL have shared dispatch outputs x_corner, y_corner, z_corner (COORD_WIDTH each), cube_id (WORLD_BITS) and highlight (1), all valid in the ch_start cycle.
REQ-012 SHALL have status outputs busy (1), done (1, pulse), looked_at_cube (WORLD_BITS), looked_at_normal (3 x NORMAL_WIDTH) and cubes_drawn (WORLD_BITS+1).

Function
REQ-013 States SHALL be IDLE, FETCH, DISPATCH, DRAIN, COMMIT.
REQ-014 IDLE: on start, SHALL clear addr, cubes_drawn and best_depth (to all ones), set busy and go to FETCH; start SHALL be ignored in any other state.
REQ-015 FETCH: SHALL hold world_read_addr for READ_LATENCY cycles, then sample world_read; valid=0 SHALL advance addr (or go to DRAIN at the last entry); valid=1 SHALL go to DISPATCH.
REQ-016 DISPATCH: a channel SHALL be free when ch_busy=0 and its pending flag is clear; the lowest-index free channel SHALL get a one-cycle ch_start, and the machine SHALL stall until one is free.
REQ-017 Corners SHALL carry the world fields in bits [COORD_WIDTH-1:COORD_WIDTH/2], with the lower half zero.
REQ-018 Pending[i] SHALL set on ch_start[i] and clear on ch_done[i]; ch_done on a channel that is not pending SHALL be ignored.
REQ-019 Each channel SHALL record the cube_id it was dispatched; cubes_drawn SHALL increment on every ch_start.
REQ-020 highlight SHALL be 1 iff cube_id equals looked_at_cube from the previous frame.
REQ-021 After dispatch, the machine SHALL advance addr and return to FETCH, or go to DRAIN after entry WORLD_SIZE-1.
REQ-022 Pick: in every non-IDLE cycle, each ch_hit[i] with depth strictly less than best_depth SHALL replace best_depth, best_id and best_normal; within the same cycle the lowest channel index SHALL win ties; across cycles the earlier hit SHALL win.
REQ-023 DRAIN: the machine SHALL wait until all pending flags and ch_busy are zero, then go to COMMIT.
REQ-024 COMMIT (one cycle): SHALL set looked_at_cube to best_id, or to all ones if best_depth is all ones; SHALL set looked_at_normal to best_normal; SHALL pulse done, clear busy and go to IDLE.
REQ-025 A ch_done and a ch_start on the same channel in the same cycle SHALL leave pending set.

Reset
REQ-026 Reset SHALL force state IDLE, ch_start=0, busy=0, done=0, pending=0, world_read_addr=0, corners=0, cube_id=0, highlight=0, cubes_drawn=0, looked_at_cube=all ones and looked_at_normal=0, including mid-frame.

Structure
REQ-027 The state enum, the world entry field offsets and the NO_CUBE (all ones) constant SHALL live in shared package world_pkg.
REQ-028 Picking SHALL be one sub-module, center_pick_reducer: an NUM_CH-input, registered min-depth reducer.

Verification
REQ-029 Scenario 1: all entries invalid, start -> done exactly WORLD_SIZE*(READ_LATENCY+1)+2 cycles after start (±1), cubes_drawn=0, looked_at_cube=all ones.
REQ-030 Scenario 2: entries 3 and 4 valid, NUM_CH=2 -> cube 3 dispatched on ch0 and cube 4 on ch1 while ch0 is busy; the 5 at entry 3 appears on x_corner as 0x00050000.
REQ-031 Scenario 3: ch0 hits at depth 40 (cube 3) and ch1 at depth 40 in the same cycle -> looked_at_cube=3; next frame highlight=1 only with cube 3.
REQ-032 Scenario 4: both channels held busy -> dispatch stalls, addr frozen, ch_start low; releasing ch1 -> cube dispatched on ch1.
REQ-033 Scenario 5: rst_n_in low mid-DISPATCH -> all outputs at reset values immediately; a new start runs the frame normally.
REQ-034 Scenario 6: start pulsed while busy -> ignored, cubes_drawn unchanged.
